rr_timeslice_arbiter: RTL and testbench

Round-robin arbiter that shares one resource among NUM_REQ requesters, with a bounded timeslice per grant.
- Slice length is tracked by an internal mod-SLICE counter.
- Ownership ends when the owner drops its request, or when the slice expires (forced).
- Sits in front of any shared datapath unit; its grant/grant_id outputs drive the resource mux select.

---
 rtl/rr_timeslice_arbiter.sv | 116 +++++++++++
 tb/tb_rr_timeslice_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_timeslice_arbiter.sv
// Round-robin arbiter with a bounded timeslice per grant and a one-cycle turnaround gap between owners.
// Optional RR_ARB_LOCK_EN adds a lock input that suppresses slice expiry while held.
module rr_timeslice_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SLICE   = 8,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = $clog2(SLICE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
`ifdef RR_ARB_LOCK_EN
  input  logic               lock,
`endif
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic [CNT_W-1:0]   slice_cnt,
  output logic               expired
);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLICE - 1);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_d;
  logic [ID_W-1:0]      gid_d, last_q, last_d, win_id;
  logic [CNT_W-1:0]     cnt_d;
  logic                 exp_d, win_vld, lock_on;

`ifdef RR_ARB_LOCK_EN
  assign lock_on = lock;
`else
  assign lock_on = 1'b0;
`endif

  // Scan from furthest to nearest so the nearest requester after last_q wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(last_q) + 1 + i) % NUM_REQ;
      if (req[idx]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant;
    gid_d   = grant_id;
    cnt_d   = slice_cnt;
    last_d  = last_q;
    exp_d   = 1'b0;
    if (enable) begin
      unique case (state_q)
        IDLE, GAP: begin
          if (win_vld) begin
            grant_d         = '0;
            grant_d[win_id] = 1'b1;
            gid_d           = win_id;
            last_d          = win_id;
            cnt_d           = '0;
            state_d         = OWN;
          end else begin
            state_d = IDLE;
          end
        end
        OWN: begin
          if (!req[grant_id]) begin
            grant_d = '0;
            cnt_d   = '0;
            state_d = GAP;
          end else if (slice_cnt == CNT_MAX) begin
            // Locked owners sit saturated at CNT_MAX until lock drops.
            if (!lock_on) begin
              grant_d = '0;
              cnt_d   = '0;
              exp_d   = 1'b1;
              state_d = GAP;
            end
          end else begin
            cnt_d = slice_cnt + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant     <= '0;
      grant_id  <= '0;
      slice_cnt <= '0;
      expired   <= 1'b0;
      last_q    <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q   <= state_d;
      grant     <= grant_d;
      grant_id  <= gid_d;
      slice_cnt <= cnt_d;
      expired   <= exp_d;
      last_q    <= last_d;
    end
  end

  assign busy = |grant;

endmodule

// File: tb/tb_rr_timeslice_arbiter.sv
// Scoreboard bench for rr_timeslice_arbiter (NUM_REQ=4, SLICE=4): a cycle model pushes
// expected outputs as stimulus is driven; they are popped and compared after each edge.
module tb_rr_timeslice_arbiter;
  localparam int N = 4;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         lock = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         busy;
  logic [1:0]   slice_cnt;
  logic         expired;

  rr_timeslice_arbiter #(.NUM_REQ(N), .SLICE(S)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
`ifdef RR_ARB_LOCK_EN
    .lock(lock),
`endif
    .req(req), .grant(grant), .grant_id(grant_id), .busy(busy),
    .slice_cnt(slice_cnt), .expired(expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] g;
    int           id;
    int           cnt;
    logic         e;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nmis = 0;

  // Reference model: 0=idle 1=own 2=gap
  int           m_st, m_id, m_cnt, m_last;
  logic [N-1:0] m_g;
  logic         m_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    if (obs !== expv) begin
      nmis++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_g = '0; m_id = 0; m_cnt = 0; m_e = 1'b0; m_last = N - 1;
  endtask

  task automatic model_step();
    logic lk;
`ifdef RR_ARB_LOCK_EN
    lk = lock;
`else
    lk = 1'b0;
`endif
    m_e = 1'b0;
    if (!enable) return;
    if (m_st == 1) begin
      if (!req[m_id]) begin
        m_g = '0; m_cnt = 0; m_st = 2;
      end else if (m_cnt == S - 1) begin
        if (!lk) begin
          m_g = '0; m_cnt = 0; m_e = 1'b1; m_st = 2;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      int w;
      w = -1;
      for (int k = 1; k <= N; k++) begin
        if (req[(m_last + k) % N]) begin
          w = (m_last + k) % N;
          break;
        end
      end
      if (w >= 0) begin
        m_g = '0; m_g[w] = 1'b1; m_id = w; m_last = w; m_cnt = 0; m_st = 1;
      end else begin
        m_st = 0;
      end
    end
  endtask

  // Drive is already applied; predict, clock, then compare the popped prediction.
  task automatic cyc(input int n = 1);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      model_step();
      x.g = m_g; x.id = m_id; x.cnt = m_cnt; x.e = m_e;
      q.push_back(x);
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        check("queue_empty", 1, 0);
      end else begin
        x = q.pop_front();
        check("grant", 32'(grant), 32'(x.g));
        check("busy", 32'(busy), 32'(|x.g));
        check("slice_cnt", 32'(slice_cnt), 32'(x.cnt));
        check("expired", 32'(expired), 32'(x.e));
        if (x.g != '0) check("grant_id", 32'(grant_id), 32'(x.id));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; enable = 1'b0; lock = 1'b0;
    #2;
    model_reset();
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cnt", 32'(slice_cnt), 0);
    check("rst_exp", 32'(expired), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Sole requester: grant, count to 3, expire, gap, regrant.
    enable = 1'b1; req = 4'b0001;
    cyc(1);
    check("s1_grant0", 32'(grant), 32'h1);
    cyc(3);
    check("s1_cnt3", 32'(slice_cnt), 3);
    cyc(1);
    check("s1_expired", 32'(expired), 1);
    check("s1_gap", 32'(grant), 0);
    cyc(1);
    check("s1_regrant", 32'(grant), 32'h1);

    // All requesting: full rotation with gaps.
    req = '0; cyc(3);
    req = 4'b1111; cyc(26);

    // Owner 2 releases at slice_cnt=1; next above 2 wins after the gap.
    do_reset();
    enable = 1'b1; req = 4'b0100;
    cyc(2);
    check("s3_cnt1", 32'(slice_cnt), 1);
    req = 4'b1011;
    cyc(1);
    check("s3_rel_grant", 32'(grant), 0);
    check("s3_rel_noexp", 32'(expired), 0);
    cyc(1);
    check("s3_next", 32'(grant), 32'h8);

    // Release coinciding with expiry.
    do_reset();
    enable = 1'b1; req = 4'b0001;
    cyc(4);
    req = 4'b0000;
    cyc(1);
    check("s4_grant", 32'(grant), 0);
    check("s4_noexp", 32'(expired), 0);

    // enable low mid-slice.
    do_reset();
    enable = 1'b1; req = 4'b0001;
    cyc(3);
    enable = 1'b0;
    cyc(5);
    check("s5_hold_cnt", 32'(slice_cnt), 2);
    check("s5_hold_grant", 32'(grant), 32'h1);
    enable = 1'b1;
    cyc(2);
    check("s5_expired", 32'(expired), 1);

    // Async reset mid-grant.
    do_reset();
    enable = 1'b1; req = 4'b0100;
    cyc(1);
    check("s6_own2", 32'(grant), 32'h4);
    #3;
    rst_n = 1'b0;
    #1;
    check("s6_async_grant", 32'(grant), 0);
    check("s6_async_busy", 32'(busy), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; req = 4'b1111;
    cyc(1);
    check("s6_first0", 32'(grant), 32'h1);

`ifdef RR_ARB_LOCK_EN
    do_reset();
    enable = 1'b1; lock = 1'b1; req = 4'b0010;
    cyc(8);
    check("lk_sat", 32'(slice_cnt), 3);
    check("lk_noexp", 32'(expired), 0);
    lock = 1'b0;
    cyc(1);
    check("lk_expired", 32'(expired), 1);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      req = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) req = req | N'(1 << $urandom_range(0, 3));
      enable = ($urandom_range(0, 7) != 0);
      lock = ($urandom_range(0, 5) == 0);
      cyc(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
